pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised in-order pipeline controller for the core: tracks STAGES in-flight slots after decode (EX..WB).
//  Detects RAW hazards between decode sources and in-flight writers; stalls IF/ID and inserts EX bubbles.
//  Flushes on taken branch and freezes the pipe on external stalls.
//  Replaces fixed, hazard-blind IF/ID..MEM/WB sequencing; optionally drives forwarding selects.
// PARAMETERS
//  STAGES   3  tracked slots after ID; slot0=EX, slot1=MEM, slot STAGES-1=WB (min 2)
//  REG_AW   5  register-address width
//  NUM_SRC  2  decode source operands checked
//  CNT_W    16 hazard-stall counter width
// PORTS
//  clk           in  1                clock, rising edge
//  rst           in  1                asynchronous, active-low reset
//  id_valid      in  1                ID holds a real instruction
//  id_rd         in  REG_AW           ID destination register
//  id_reg_write  in  1                ID instruction writes id_rd
//  id_is_load    in  1                ID instruction is a memory load
//  id_src        in  NUM_SRC*REG_AW   ID source registers, src j at [j*REG_AW +: REG_AW]
//  id_src_used   in  NUM_SRC          per-source read enable
//  br_taken      in  1                taken branch resolved in EX (slot0); held until accepted
//  stall_ext     in  1                external freeze, e.g. memory wait
//  id_stall      out 1                hold PC and IF/ID register
//  ex_bubble     out 1                slot0 loads a bubble this edge
//  flush_ifid    out 1                clear IF/ID register
//  flush_idex    out 1                clear ID/EX register
//  st_valid      out STAGES           per-slot valid
//  st_rd         out STAGES*REG_AW    per-slot destination
//  st_reg_write  out STAGES           per-slot write enable (already gated by st_valid)
//  fwd_sel       out NUM_SRC*SW       SW=$clog2(STAGES+1); 0=regfile, k=slot k-1 (FORWARD_EN only, else 0)
//  hazard_cnt    out CNT_W            cycles stalled by RAW hazards
// BEHAVIOUR
//  - Reset (async, rst=0): st_valid, st_rd, st_reg_write, per-slot load flags and hazard_cnt cleared.
//    Combinational outputs follow from cleared state. Reset mid-operation discards all in-flight slots.
//  - match(j,k): id_src_used[j], id_src[j]!=0, st_valid[k], st_reg_write[k], st_rd[k]==id_src[j].
//    Register 0 never matches.
//  - Without FORWARD_EN: raw = id_valid & OR over j,k of match(j,k).
//  - With FORWARD_EN: raw = id_valid & OR over j of match(j,0) where slot0 is a load (load-use, 1 bubble).
//  - Priority, highest first: stall_ext > br_taken > raw.
//  - stall_ext=1: all slots hold; id_stall=1; ex_bubble=0; flush_*=0; counter holds.
//  - br_taken & !stall_ext: flush_ifid=flush_idex=1, ex_bubble=1, id_stall=0.
//    Next edge slot0 <= bubble; older slots shift.
//  - raw & !br_taken & !stall_ext: id_stall=1, ex_bubble=1, hazard_cnt += 1.
//    The counter saturates at all-ones.
//  - Otherwise each edge shifts slot k -> k+1; slot0 <= {id_valid, id_rd, id_reg_write&id_valid, id_is_load}.
//    The WB slot is dropped.
//  - Latency: ID to slot0 is 1 edge; slot k to k+1 is 1 edge. Outputs other than slot state are combinational, same cycle.
//  - Register file writes at the WB edge. A WB-slot match therefore stalls 1 cycle without forwarding.
// CONFIGURATION
//  - FORWARD_EN defined: fwd_sel[j] = 1+lowest k with match(j,k) (youngest writer wins).
//    A load in slot0 is never selected (stall instead). Only load-use stalls.
//  - FORWARD_EN undefined: fwd_sel tied 0; every in-flight match stalls until the writer leaves slot STAGES-1.
// TESTING
//  1. rst=0 mid-run with 3 valid slots -> st_valid=000, hazard_cnt=0 immediately (async), id_stall=0.
//  2. No FORWARD_EN: add r3 then sub r4,r3 -> id_stall=1 for 3 cycles, 3 bubbles, hazard_cnt=3.
//  3. FORWARD_EN: add r3; sub r4,r3 -> no stall, fwd_sel[0]=1. Next instr using r3 -> fwd_sel=2.
//  4. FORWARD_EN: lw r5; add r6,r5 -> 1 stall cycle, then fwd_sel[0]=2 (MEM slot), hazard_cnt=1.
//  5. br_taken with raw=1 same cycle -> flush_ifid=flush_idex=1, ex_bubble=1, id_stall=0, hazard_cnt unchanged.
//  6. stall_ext=1 for 4 cycles with br_taken=1 -> slots frozen, flush_*=0.
//     Flush fires on first cycle stall_ext=0. Also check src r0 vs rd r0 never stalls.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: tracks the EX..WB slots, stalls on RAW hazards, flushes on taken branches.
// Optional FORWARD_EN macro enables forwarding selects so that only load-use hazards stall.
module pipe_hazard_ctrl #(
    parameter int STAGES  = 3,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16,
    localparam int SW     = $clog2(STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_reg_write,
    input  logic                        id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic                        br_taken,
    input  logic                        stall_ext,
    output logic                        id_stall,
    output logic                        ex_bubble,
    output logic                        flush_ifid,
    output logic                        flush_idex,
    output logic [STAGES-1:0]           st_valid,
    output logic [STAGES*REG_AW-1:0]    st_rd,
    output logic [STAGES-1:0]           st_reg_write,
    output logic [NUM_SRC*SW-1:0]       fwd_sel,
    output logic [CNT_W-1:0]            hazard_cnt
);

    logic [STAGES-1:0]          r_valid;
    logic [STAGES*REG_AW-1:0]   r_rd;
    logic [STAGES-1:0]          r_wr;
    logic [STAGES-1:0]          r_load;
    logic [CNT_W-1:0]           r_cnt;

    logic [NUM_SRC-1:0][STAGES-1:0] w_match;
    logic                           w_raw;
    logic                           w_bubble;
    logic                           w_cnt_inc;
    logic                           w_s0_valid;
    logic [REG_AW-1:0]              w_s0_rd;
    logic                           w_s0_wr;
    logic                           w_s0_load;

    // Register 0 is hardwired, so it never creates a dependency.
    always_comb begin
        w_match = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = 0; k < STAGES; k++) begin
                w_match[j][k] = id_src_used[j]
                              && (id_src[j*REG_AW +: REG_AW] != '0)
                              && r_valid[k] && r_wr[k]
                              && (r_rd[k*REG_AW +: REG_AW] == id_src[j*REG_AW +: REG_AW]);
            end
        end
    end

`ifdef FORWARD_EN
    // Only a load still in EX cannot be forwarded; everything else is bypassed.
    always_comb begin
        w_raw = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (w_match[j][0] && r_load[0]) w_raw = 1'b1;
        end
        w_raw = w_raw & id_valid;
    end

    // Scan oldest to youngest so the youngest eligible writer wins.
    always_comb begin
        fwd_sel = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (w_match[j][k] && !(k == 0 && r_load[0])) begin
                    fwd_sel[j*SW +: SW] = SW'(k + 1);
                end
            end
        end
    end
`else
    // Without bypassing, any in-flight writer must retire past WB first.
    always_comb begin
        w_raw   = id_valid & (|w_match);
        fwd_sel = '0;
    end
`endif

    always_comb begin
        id_stall   = stall_ext | (w_raw & ~br_taken);
        w_bubble   = ~stall_ext & (br_taken | w_raw);
        w_cnt_inc  = ~stall_ext & ~br_taken & w_raw;
        ex_bubble  = w_bubble;
        flush_ifid = ~stall_ext & br_taken;
        flush_idex = ~stall_ext & br_taken;

        w_s0_valid = id_valid & ~w_bubble;
        w_s0_rd    = w_bubble ? '0 : id_rd;
        w_s0_wr    = id_reg_write & w_s0_valid;
        w_s0_load  = id_is_load & w_s0_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_load  <= '0;
            r_cnt   <= '0;
        end else if (!stall_ext) begin
            r_valid <= {r_valid[STAGES-2:0], w_s0_valid};
            r_rd    <= {r_rd[(STAGES-1)*REG_AW-1:0], w_s0_rd};
            r_wr    <= {r_wr[STAGES-2:0], w_s0_wr};
            r_load  <= {r_load[STAGES-2:0], w_s0_load};
            if (w_cnt_inc && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign st_valid     = r_valid;
    assign st_rd        = r_rd;
    assign st_reg_write = r_wr & r_valid;
    assign hazard_cnt   = r_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against an in-flight instruction list model.
module tb_pipe_hazard_ctrl;

    localparam int STAGES  = 3;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;
    localparam int SW      = $clog2(STAGES + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        id_valid;
    logic [REG_AW-1:0]           id_rd;
    logic                        id_reg_write;
    logic                        id_is_load;
    logic [NUM_SRC*REG_AW-1:0]   id_src;
    logic [NUM_SRC-1:0]          id_src_used;
    logic                        br_taken;
    logic                        stall_ext;
    logic                        id_stall;
    logic                        ex_bubble;
    logic                        flush_ifid;
    logic                        flush_idex;
    logic [STAGES-1:0]           st_valid;
    logic [STAGES*REG_AW-1:0]    st_rd;
    logic [STAGES-1:0]           st_reg_write;
    logic [NUM_SRC*SW-1:0]       fwd_sel;
    logic [CNT_W-1:0]            hazard_cnt;

    pipe_hazard_ctrl #(
        .STAGES(STAGES), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_src(id_src), .id_src_used(id_src_used),
        .br_taken(br_taken), .stall_ext(stall_ext),
        .id_stall(id_stall), .ex_bubble(ex_bubble),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .st_valid(st_valid), .st_rd(st_rd), .st_reg_write(st_reg_write),
        .fwd_sel(fwd_sel), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    // In-flight instructions, index = age in cycles after leaving ID.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t m[STAGES];
    int     m_cnt;
    int     n_chk  = 0;
    int     n_fail = 0;
    bit     last_stall;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit depends(int j, int k);
        int s;
        s = int'(id_src[j*REG_AW +: REG_AW]);
        return id_src_used[j] && (s != 0) && m[k].v && m[k].wr && (m[k].rd == s);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < STAGES; k++) m[k] = '{0, 0, 0, 0};
        m_cnt = 0;
    endtask

    task automatic drive(input bit v, input int rd, input bit wr, input bit ld,
                         input int s0, input int s1, input logic [1:0] used,
                         input bit br, input bit se);
        id_valid     = v;
        id_rd        = REG_AW'(rd);
        id_reg_write = wr;
        id_is_load   = ld;
        id_src       = {REG_AW'(s1), REG_AW'(s0)};
        id_src_used  = used;
        br_taken     = br;
        stall_ext    = se;
    endtask

    // One cycle: compare DUT against the model at the falling edge, then advance the model.
    task automatic step();
        bit raw, bub;
        logic [NUM_SRC*SW-1:0]     e_fwd;
        logic [STAGES-1:0]         e_v, e_w;
        logic [STAGES*REG_AW-1:0]  e_rd, a_rd;
        raw   = 0;
        e_fwd = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = 0; k < STAGES; k++) begin
`ifdef FORWARD_EN
                if (k == 0 && m[0].ld && depends(j, k)) raw = 1;
`else
                if (depends(j, k)) raw = 1;
`endif
            end
`ifdef FORWARD_EN
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (depends(j, k) && !(k == 0 && m[0].ld)) e_fwd[j*SW +: SW] = SW'(k + 1);
            end
`endif
        end
        raw = raw & id_valid;
        bub = !stall_ext && (br_taken || raw);

        @(negedge clk);
        e_rd = '0;
        a_rd = '0;
        for (int k = 0; k < STAGES; k++) begin
            e_v[k] = m[k].v;
            e_w[k] = m[k].v & m[k].wr;
            if (m[k].v) begin
                e_rd[k*REG_AW +: REG_AW] = REG_AW'(m[k].rd);
                a_rd[k*REG_AW +: REG_AW] = st_rd[k*REG_AW +: REG_AW];
            end
        end
        chk_eq("st_valid", st_valid, e_v);
        chk_eq("st_reg_write", st_reg_write, e_w);
        chk_eq("st_rd", a_rd, e_rd);
        chk_eq("id_stall", id_stall, stall_ext || (raw && !br_taken));
        chk_eq("ex_bubble", ex_bubble, bub);
        chk_eq("flush_ifid", flush_ifid, !stall_ext && br_taken);
        chk_eq("flush_idex", flush_idex, !stall_ext && br_taken);
        chk_eq("fwd_sel", fwd_sel, e_fwd);
        chk_eq("hazard_cnt", hazard_cnt, m_cnt);
        last_stall = id_stall;

        @(posedge clk);
        if (!stall_ext) begin
            for (int k = STAGES - 1; k > 0; k--) m[k] = m[k-1];
            if (bub) m[0] = '{0, 0, 0, 0};
            else     m[0] = '{id_valid, int'(id_rd), id_reg_write & id_valid, id_is_load & id_valid};
            if (raw && !br_taken && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
    endtask

    // Asserts reset between edges and checks that it takes effect without a clock.
    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_eq("rst_st_valid", st_valid, '0);
        chk_eq("rst_hazard_cnt", hazard_cnt, '0);
        chk_eq("rst_id_stall", id_stall, 1'b0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int stalls;
        clear_model();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_eq("por_st_valid", st_valid, '0);
        chk_eq("por_hazard_cnt", hazard_cnt, '0);
        rst = 1'b1;

        // Three independent writers in flight, then reset mid-run.
        for (int i = 1; i <= 3; i++) begin
            drive(1, i, 1, 0, 0, 0, 2'b00, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk_eq("full_st_valid", st_valid, 3'b111);
        apply_reset();

        // add r3 followed by a dependent sub r4,r3.
        drive(1, 3, 1, 0, 0, 0, 2'b00, 0, 0);
        step();
        drive(1, 4, 1, 0, 3, 0, 2'b01, 0, 0);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_stall) stalls++;
            else break;
        end
`ifdef FORWARD_EN
        chk_eq("dep_stall_cycles", stalls, 0);
        chk_eq("dep_hazard_cnt", hazard_cnt, 0);
`else
        chk_eq("dep_stall_cycles", stalls, 3);
        chk_eq("dep_hazard_cnt", hazard_cnt, 3);
`endif

        // External freeze overlapping a held taken branch.
        drive(1, 5, 1, 1, 0, 0, 2'b00, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 6, 1, 0, 5, 0, 2'b01, 1, 1);
            step();
        end
        drive(1, 6, 1, 0, 5, 0, 2'b01, 1, 0);
        step();

        // r0 as source and destination never creates a dependency.
        drive(1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        step();
        drive(1, 7, 1, 0, 0, 0, 2'b11, 0, 0);
        step();

        for (int n = 0; n < 2000; n++) begin
            if (n % 300 == 299) apply_reset();
            drive(($urandom % 4) != 0, $urandom_range(0, 3), $urandom % 2, ($urandom % 4) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom % 4),
                  ($urandom % 8) == 0, ($urandom % 6) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
